mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RV32I pipeline. It reads the EX/MEM pipeline interface and runs one load or store per instruction over a req/gnt/rvalid data-memory port, with byte/halfword alignment and sign/zero extension. It drives the MEM/WB interface and stalls the pipeline while an access is outstanding. Misaligned accesses and bus timeouts are reported.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles waited in REQ/WAIT before abort; minimum 1.

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `inputs`  exmem_if.rd  —  ctrl.{RegWrite, ResultSrc[1:0], MemWrite, funct3[2:0]}, data.{ALUResult, WriteData, PCPlus4, Rd, ImmExt}
- `outputs`  memwb_if.wr  —  ctrl.{RegWrite, ResultSrc}, data.{ALUResult, ReadData, PCPlus4, Rd, ImmExt}
- `dmem_req`  out  1  access request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  32  word address, `{ALUResult[31:2], 2'b00}`
- `dmem_wdata`  out  32  lane-aligned store data
- `dmem_be`  out  4  byte enables
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  load data valid
- `dmem_rdata`  in  32  load data
- `StallM`  out  1  to hazard unit: hold F/D/E/M
- `MisalignM`  out  1  one-cycle misaligned-access flag
- `BusErrM`  out  1  one-cycle timeout flag

## Operation
- Load = `ResultSrc == RESULT_MEM (2'b01)`. Store = `MemWrite`. Bubbles have neither and pass straight through.
- Alignment: LH/LHU/SH need `addr[0]==0`. LW/SW need `addr[1:0]==0`. Load funct3 011/110/111 is treated as LW.
- Misaligned access: no request is issued. `MisalignM=1`, `StallM=0`, and `outputs.ctrl.RegWrite` is forced to 0 for that cycle.
- Store lanes:
  - SB: `be = 1<<addr[1:0]`, wdata = byte replicated ×4.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, wdata = half replicated ×2.
  - SW: `be = 4'b1111`.
- Loads:
  - Lane is selected by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - `dmem_be` on a load reflects the access size.
- FSM states are IDLE, REQ and WAIT. Request outputs come from `inputs` combinationally and must stay stable until gnt.
  - IDLE, aligned op present: `dmem_req=1`. No gnt → REQ. Gnt on a store → done, stay IDLE. Gnt on a load → WAIT.
  - REQ: `dmem_req=1`. Gnt on a store → IDLE (done). Gnt on a load → WAIT.
  - WAIT: `dmem_req=0`. rvalid → IDLE (done), and ReadData = extended rdata in that cycle.
- `StallM` = aligned memory op present AND not completing this cycle.
- Timeout:
  - The counter clears on entering REQ or WAIT and increments each cycle spent there.
  - When the count reaches `TIMEOUT_CYCLES`, the access aborts: `BusErrM=1`, `StallM=0`, `RegWrite` forced to 0, → IDLE.
- One access outstanding at most. `dmem_rvalid` in IDLE or REQ is ignored.
- Pass-through: RegWrite (unless forced to 0), ResultSrc, ALUResult, PCPlus4, Rd, ImmExt. ReadData is 0 when not completing a load.

## Timing
- Reset:
  - FSM → IDLE, counter → 0.
  - While reset is high: `dmem_req`, `StallM`, `MisalignM` and `BusErrM` are 0.
- Reset mid-access abandons it. The memory shares `reset`, so no stale response follows.
- Store with same-cycle gnt: 0 stall cycles.
- Load with gnt in cycle N and rvalid in N+1: StallM high in N, low in N+1 (1 stall cycle).
- Each extra gnt or rvalid wait cycle adds one stall cycle.
- rvalid must come no earlier than the cycle after gnt.
- Gnt and timeout expiry in the same cycle: gnt wins.
- The cycle after completion, `inputs` holds the next instruction, which is evaluated in IDLE.

## Structure
- Package `mem_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t`
  - `RESULT_MEM`
  - funct3 constants `F3_B/H/W/BU/HU`
- Sub-module `load_store_align` (combinational) computes be, wdata, the misalign flag and extended load data from funct3, `addr[1:0]`, WriteData and rdata.
- `mem_stage` holds the FSM, the timeout counter and the pass-through.

## Test plan
- SB, addr 0x1003, WriteData 0xA5, gnt same cycle → `be=4'b1000`, `wdata=0xA5A5A5A5`, `StallM` never high.
- LB, addr 0x2001, gnt in N, rvalid in N+1 with rdata 0x0000_8000 → ReadData 0xFFFF_FF80, exactly 1 stall cycle.
- LHU, addr 0x2002, gnt delayed 3 cycles, rdata 0xBEEF_0000 → ReadData 0x0000_BEEF, req held stable for 4 cycles, 4 stall cycles.
- LW, addr 0x3002 → no `dmem_req`, `MisalignM=1` for 1 cycle, `RegWrite` forced to 0, `StallM=0`.
- `TIMEOUT_CYCLES=4`, LW with no gnt → `BusErrM` pulses when the counter reaches 4, `StallM` drops that cycle, `RegWrite` forced to 0.
- Reset asserted in WAIT, then an aligned SW → FSM restarts in IDLE, outputs 0 during reset, then a clean SW.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic [2:0] funct3;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } exmem_data_t;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [31:0] PCPlus4;
    logic [4:0]  Rd;
    logic [31:0] ImmExt;
  } memwb_data_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline register interfaces on either side of the memory stage.
interface exmem_if;
  mem_pkg::exmem_ctrl_t ctrl;
  mem_pkg::exmem_data_t data;
  modport rd (input ctrl, input data);
  modport wr (output ctrl, output data);
endinterface

interface memwb_if;
  mem_pkg::memwb_ctrl_t ctrl;
  mem_pkg::memwb_data_t data;
  modport rd (input ctrl, input data);
  modport wr (output ctrl, output data);
endinterface

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; the access size comes from funct3[1:0] and any
// encoding other than byte/half is handled as a full word.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Select lanes, replicate store data and extend load data by access size
  always_comb begin
    be        = 4'b1111;
    wdata     = write_data;
    misalign  = |addr_lo;
    load_data = shifted;
    case (funct3[1:0])
      F3_B[1:0]: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{write_data[7:0]}};
        misalign  = 1'b0;
        load_data = (funct3 == F3_BU) ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H[1:0]: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{write_data[15:0]}};
        misalign  = addr_lo[0];
        load_data = (funct3 == F3_HU) ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata     = write_data;
        misalign  = |addr_lo;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one load or store per instruction over a
// req/gnt/rvalid port, stalls the pipeline while it is outstanding and
// flags misaligned accesses and bus timeouts.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  exmem_if.rd         inputs,
  memwb_if.wr         outputs,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] tmo_cnt;

  logic        is_load, is_store, mem_op, aligned_op, misalign, misalign_evt;
  logic        timed_out, req_raw, done, abort, load_done, reg_write;
  logic [3:0]  be;
  logic [31:0] wdata, load_data, read_data;

  assign is_load    = (inputs.ctrl.ResultSrc == RESULT_MEM);
  assign is_store   = inputs.ctrl.MemWrite;
  assign mem_op     = is_load | is_store;
  assign aligned_op = mem_op & ~misalign;
  assign timed_out  = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

  load_store_align u_align (
    .funct3     (inputs.ctrl.funct3),
    .addr_lo    (inputs.data.ALUResult[1:0]),
    .write_data (inputs.data.WriteData),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .misalign   (misalign),
    .load_data  (load_data)
  );

  // Next-state and handshake decode; a grant or rvalid beats a timeout that expires in the same cycle
  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_op) begin
          req_raw = 1'b1;
          if (dmem_gnt) begin
            if (is_store) done = 1'b1;
            else          state_next = WAIT;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        req_raw = 1'b1;
        if (dmem_gnt) begin
          if (is_store) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          done       = 1'b1;
          load_done  = 1'b1;
          state_next = IDLE;
        end else if (timed_out) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Timeout counter restarts on every entry into REQ or WAIT and counts cycles spent there
  always_ff @(posedge clk) begin
    if (reset)                    tmo_cnt <= '0;
    else if (state_next != state) tmo_cnt <= '0;
    else if (state != IDLE)       tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign misalign_evt = mem_op & misalign & (state == IDLE);
  assign reg_write    = inputs.ctrl.RegWrite & ~misalign_evt & ~abort;
  assign read_data    = load_done ? load_data : 32'h0;

  assign dmem_req   = req_raw & ~reset;
  assign dmem_we    = is_store;
  assign dmem_addr  = {inputs.data.ALUResult[31:2], 2'b00};
  assign dmem_wdata = wdata;
  assign dmem_be    = be;

  assign StallM    = ~reset & aligned_op & ~done & ~abort;
  assign MisalignM = ~reset & misalign_evt;
  assign BusErrM   = ~reset & abort;

  assign outputs.ctrl = {reg_write, inputs.ctrl.ResultSrc};
  assign outputs.data = {inputs.data.ALUResult, read_data, inputs.data.PCPlus4,
                         inputs.data.Rd, inputs.data.ImmExt};

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios followed by random loads,
// stores and bubbles, checked against a transaction-level model.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        StallM, MisalignM, BusErrM;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  exmem_if ex_bus ();
  memwb_if wb_bus ();

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .inputs      (ex_bus),
    .outputs     (wb_bus),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .StallM      (StallM),
    .MisalignM   (MisalignM),
    .BusErrM     (BusErrM)
  );

  // Access size in bytes implied by funct3
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Byte lanes touched by an access of sz bytes starting at byte offset off
  function automatic logic [3:0] lanes(input int off, input int sz);
    logic [3:0] m;
    m = 4'b0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) m[i] = 1'b1;
    return m;
  endfunction

  // Store data: every lane carries the store datum's byte (lane mod size)
  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int sz);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % sz) +: 8];
    return v;
  endfunction

  // Load result: gather sz bytes from the lane, then sign- or zero-fill
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    int          sz;
    logic [31:0] v;
    sz = size_of(f3);
    v  = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (sz < 4 && !f3[2] && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_bubble();
    ex_bus.ctrl = '{RegWrite: 1'b0, ResultSrc: 2'b00, MemWrite: 1'b0, funct3: 3'b000};
    ex_bus.data = '{ALUResult: 32'h0, WriteData: 32'h0, PCPlus4: 32'h0, Rd: 5'h0, ImmExt: 32'h0};
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, ".req"},   32'(dmem_req),  32'h0);
    checkOutput({tag, ".stall"}, 32'(StallM),    32'h0);
    checkOutput({tag, ".mis"},   32'(MisalignM), 32'h0);
    checkOutput({tag, ".berr"},  32'(BusErrM),   32'h0);
  endtask

  // One instruction: g = cycle of gnt (0 = first cycle), r = cycles from gnt to rvalid
  task automatic applyStimulus(input string tag, input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rdata,
                               input int g, input int r);
    int          off, sz, last;
    logic        memop, mis, aligned, abort, ld_done, rw, in_req;
    logic [1:0]  rs;
    logic [31:0] pc, imm, exp_rd;
    logic [4:0]  rd;
    string       c;

    off     = int'(addr[1:0]);
    sz      = size_of(f3);
    memop   = ld | st;
    mis     = memop && (off % sz != 0);
    aligned = memop && !mis;
    abort   = 1'b0;
    ld_done = 1'b0;
    if (!aligned)          last = 0;
    else if (g > T + 1)    begin last = T + 1;     abort = 1'b1; end
    else if (st)           last = g;
    else if (r > T + 1)    begin last = g + T + 1; abort = 1'b1; end
    else                   begin last = g + r;     ld_done = 1'b1; end

    rw  = 1'($urandom_range(0, 1));
    pc  = $urandom;
    imm = $urandom;
    rd  = 5'($urandom_range(0, 31));
    if (ld) rs = RESULT_MEM;
    else begin
      rs = 2'($urandom_range(0, 2));
      if (rs == RESULT_MEM) rs = 2'b11;
    end
    exp_rd = ld_done ? exp_load(f3, off, rdata) : 32'h0;

    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ex_bus.ctrl = '{RegWrite: rw, ResultSrc: rs, MemWrite: st, funct3: f3};
        ex_bus.data = '{ALUResult: addr, WriteData: wd, PCPlus4: pc, Rd: rd, ImmExt: imm};
      end
      dmem_gnt    = aligned && (k == g);
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (ld && aligned && (k == g + r)) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end else if (ld && aligned && k < g && $urandom_range(0, 3) == 0) begin
        dmem_rvalid = 1'b1;
      end
      #3;
      c      = $sformatf("%s.c%0d", tag, k);
      in_req = aligned && (k <= g);
      checkOutput({c, ".req"},   32'(dmem_req),  32'(in_req));
      checkOutput({c, ".stall"}, 32'(StallM),    32'(aligned && k < last));
      checkOutput({c, ".berr"},  32'(BusErrM),   32'(abort && k == last));
      checkOutput({c, ".mis"},   32'(MisalignM), 32'(mis && k == 0));
      checkOutput({c, ".rw"},    32'(wb_bus.ctrl.RegWrite),
                  32'(rw && !mis && !(abort && k == last)));
      checkOutput({c, ".rdata"}, wb_bus.data.ReadData, (k == last) ? exp_rd : 32'h0);
      if (in_req) begin
        checkOutput({c, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        checkOutput({c, ".we"},   32'(dmem_we), 32'(st));
        checkOutput({c, ".be"},   32'(dmem_be), 32'(lanes(off, sz)));
        if (st) checkOutput({c, ".wdata"}, dmem_wdata, exp_wdata(wd, sz));
      end
      if (k == last) begin
        checkOutput({c, ".rsrc"}, 32'(wb_bus.ctrl.ResultSrc), 32'(rs));
        checkOutput({c, ".alu"},  wb_bus.data.ALUResult, addr);
        checkOutput({c, ".pc4"},  wb_bus.data.PCPlus4, pc);
        checkOutput({c, ".rd"},   32'(wb_bus.data.Rd), 32'(rd));
        checkOutput({c, ".imm"},  wb_bus.data.ImmExt, imm);
      end
    end
  endtask

  // Directed scenarios, reset-in-flight, then random traffic
  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind, g, r, sz;

    reset = 1'b1;
    drive_bubble();
    @(negedge clk); #3; check_quiet("reset0");
    @(negedge clk); #3; check_quiet("reset1");
    reset = 1'b0;

    applyStimulus("sb",      1'b0, 1'b1, F3_B,   32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1);
    applyStimulus("lb",      1'b1, 1'b0, F3_B,   32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1);
    applyStimulus("lhu",     1'b1, 1'b0, F3_HU,  32'h0000_2002, 32'h0, 32'hBEEF_0000, 3, 1);
    applyStimulus("lw_mis",  1'b1, 1'b0, F3_W,   32'h0000_3002, 32'h0, 32'h0, 0, 1);
    applyStimulus("lw_tmo",  1'b1, 1'b0, F3_W,   32'h0000_3000, 32'h0, 32'h0, 1000, 1);
    applyStimulus("sh_hi",   1'b0, 1'b1, F3_H,   32'h0000_4006, 32'h1234_CAFE, 32'h0, 2, 1);
    applyStimulus("sh_mis",  1'b0, 1'b1, F3_H,   32'h0000_4005, 32'h1234_CAFE, 32'h0, 0, 1);
    applyStimulus("lh_neg",  1'b1, 1'b0, F3_H,   32'h0000_5002, 32'h0, 32'h9ABC_0000, 1, 2);
    applyStimulus("lw_f6",   1'b1, 1'b0, 3'b110, 32'h0000_5004, 32'h0, 32'hDEAD_BEEF, 0, 1);
    applyStimulus("gnt_lim", 1'b0, 1'b1, F3_W,   32'h0000_6000, 32'h5555_AAAA, 32'h0, T + 1, 1);
    applyStimulus("rv_lim",  1'b1, 1'b0, F3_BU,  32'h0000_6003, 32'h0, 32'h8100_0000, 0, T + 1);
    applyStimulus("rv_tmo",  1'b1, 1'b0, F3_W,   32'h0000_7000, 32'h0, 32'h0, 1, 1000);
    applyStimulus("bubble",  1'b0, 1'b0, F3_W,   32'h0000_7001, 32'h0, 32'h0, 0, 1);

    // Reset while a load sits in WAIT, then a clean store
    @(negedge clk);
    ex_bus.ctrl = '{RegWrite: 1'b1, ResultSrc: RESULT_MEM, MemWrite: 1'b0, funct3: F3_W};
    ex_bus.data = '{ALUResult: 32'h0000_8000, WriteData: 32'h0, PCPlus4: 32'h4, Rd: 5'd3, ImmExt: 32'h0};
    dmem_gnt    = 1'b1;
    dmem_rvalid = 1'b0;
    #3;
    checkOutput("rst_mid.req", 32'(dmem_req), 32'h1);
    @(negedge clk);
    dmem_gnt = 1'b0;
    reset    = 1'b1;
    #3; check_quiet("rst_mid.r0");
    @(negedge clk);
    drive_bubble();
    #3; check_quiet("rst_mid.r1");
    reset = 1'b0;
    applyStimulus("sw_after_rst", 1'b0, 1'b1, F3_W, 32'h0000_9000, 32'hCAFE_F00D, 32'h0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      ld   = (kind < 5);
      st   = (kind >= 5 && kind < 9);
      f3   = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      sz   = size_of(f3);
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr & ~32'(sz - 1);
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 1);
      r = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 2);
      applyStimulus($sformatf("rnd%0d", n), ld, st, f3, addr, $urandom, $urandom, g, r);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
